// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: serialises requester writes into a register bank, round-robin (fixed priority if REG_ARB_FIXED_PRIO_EN)
//   clk, rst (async active-low) | req, req_addr, req_data in | ack, err, ld_en, ld_data, busy out
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [DEPTH-1:0]      ld_en,
  output logic [WIDTH-1:0]      ld_data,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] sel, win;
  logic [AW-1:0] sel_addr, addr_q;
  logic [DEPTH-1:0] dec;
`ifdef REG_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) sel = req[i] ? PW'(i) : sel;
  end
`else
  logic [PW-1:0] ptr;
  // descending scan so the smallest offset from ptr wins
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) sel = req[(int'(ptr) + i) % NREQ] ? PW'((int'(ptr) + i) % NREQ) : sel;
  end
`endif
  assign sel_addr = req_addr[int'(sel)*AW +: AW];
  always_comb begin
    dec = '0;
    for (int d = 0; d < DEPTH; d++) dec[d] = sel_addr == AW'(d);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      win     <= '0;
      addr_q  <= '0;
      ack     <= '0;
      err     <= 1'b0;
      ld_en   <= '0;
      ld_data <= '0;
      busy    <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
      ptr     <= '0;
`endif
    end else begin
      ack   <= '0;
      err   <= 1'b0;
      ld_en <= '0;
      case (state)
        IDLE: if (|req) begin
          state   <= WRITE;
          win     <= sel;
          addr_q  <= sel_addr;
          ld_en   <= dec;
          ld_data <= req_data[int'(sel)*WIDTH +: WIDTH];
          busy    <= 1'b1;
        end
        WRITE: begin
          state <= ACK;
          ack   <= NREQ'(1) << win;
          err   <= int'(addr_q) >= DEPTH;
`ifndef REG_ARB_FIXED_PRIO_EN
          ptr   <= int'(win) == NREQ - 1 ? '0 : win + 1'b1;
`endif
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and random checks of reg_write_arbiter against a transaction-level model
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0] ack4, ack3, ld_en4;
  logic [2:0] ld_en3;
  logic [7:0] ld_data4, ld_data3;
  logic err4, err3, busy4, busy3;
  int checks = 0, failures = 0, ptr_m = 0;
  always #5 clk = ~clk;
  reg_write_arbiter #(.WIDTH(8), .NREQ(4), .DEPTH(4), .AW(2)) u4 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack4), .err(err4), .ld_en(ld_en4), .ld_data(ld_data4), .busy(busy4));
  reg_write_arbiter #(.WIDTH(8), .NREQ(4), .DEPTH(3), .AW(2)) u3 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack3), .err(err3), .ld_en(ld_en3), .ld_data(ld_data3), .busy(busy3));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(logic [3:0] r, int p);
    int s = p;
`ifdef REG_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int i = 0; i < 4; i++) if (r[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction
  task automatic idle_zero(string tag);
    chk({tag, ".ack4"}, ack4, 0);
    chk({tag, ".ack3"}, ack3, 0);
    chk({tag, ".ld_en4"}, ld_en4, 0);
    chk({tag, ".ld_en3"}, ld_en3, 0);
    chk({tag, ".busy4"}, busy4, 0);
    chk({tag, ".busy3"}, busy3, 0);
    chk({tag, ".err"}, {err4, err3}, 0);
  endtask
  // called at a negedge with the DUT idle and req already driven
  task automatic txn(string tag);
    int w;
    logic [1:0] a;
    logic [7:0] d;
    w = pick(req, ptr_m);
    a = req_addr[w*2 +: 2];
    d = req_data[w*8 +: 8];
    chk({tag, ".busy_pre"}, busy4, 0);
    @(negedge clk);
    chk({tag, ".ld_en4"}, ld_en4, 32'(1 << a));
    chk({tag, ".ld_en3"}, ld_en3, a < 3 ? 32'(1 << a) : 0);
    chk({tag, ".ld_data4"}, ld_data4, d);
    chk({tag, ".ld_data3"}, ld_data3, d);
    chk({tag, ".busy_w"}, {busy4, busy3}, 2'b11);
    chk({tag, ".ack_w"}, {ack4, ack3}, 0);
    req_addr = 8'($urandom);
    req_data = $urandom;
    @(negedge clk);
    chk({tag, ".ack4"}, ack4, 32'(1 << w));
    chk({tag, ".ack3"}, ack3, 32'(1 << w));
    chk({tag, ".err4"}, err4, 0);
    chk({tag, ".err3"}, err3, a == 3);
    chk({tag, ".ld_en_a"}, {ld_en4, ld_en3}, 0);
    chk({tag, ".ld_data_hold"}, ld_data4, d);
    chk({tag, ".busy_a"}, {busy4, busy3}, 2'b11);
    req[w] = 1'b0;
    ptr_m = (w + 1) % 4;
    @(negedge clk);
    idle_zero({tag, ".post"});
  endtask
  initial begin
    req = 4'b1111;
    req_addr = 8'($urandom);
    req_data = $urandom;
    repeat (2) @(negedge clk);
    idle_zero("rst");
    chk("rst.ld_data", {ld_data4, ld_data3}, 0);
    rst = 1'b1;
    repeat (5) begin
      req = 4'b1111;
      txn("all4");
    end
    req = 4'b0100;
    req_addr = 8'h30;
    req_data = 32'h00A5_0000;
    txn("single");
    req = 4'b0010;
    req_addr = 8'h0C;
    req_data = 32'h0000_5A00;
    txn("oor");
    req = 4'b0100;
    req_addr = 8'h10;
    @(negedge clk);
    chk("mid.ld_en_before", ld_en4, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk("mid.ld_en_async", {ld_en4, ld_en3}, 0);
    chk("mid.busy_async", {busy4, busy3}, 0);
    @(negedge clk);
    idle_zero("mid.noack");
    ptr_m = 0;
    req = 4'b1111;
    req_addr = 8'($urandom);
    rst = 1'b1;
    txn("mid.ptr0");
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) req[i] = req[i] | ($urandom_range(1) == 1);
      if (req == 0) req[$urandom_range(3)] = 1'b1;
      req_addr = 8'($urandom);
      req_data = $urandom;
      txn("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares a bank of `DEPTH` external `WIDTH`-bit load registers among `NREQ` requesters. It serialises write requests, drives one-hot load enables and a shared data bus into the register instances, and acknowledges each requester when its write has been issued. It sits between requesting agents and the register bank, and is the only block permitted to drive register load enables.

## Interface
- `WIDTH`, 8, data width of each register and of each requester's data.
- `NREQ`, 4, number of requesters (2..16).
- `DEPTH`, 4, number of registers in the bank (1..2**AW).
- `AW`, 2, register address width.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; takes effect immediately on assertion, release synchronous to `clk`.
- `req`  in  NREQ  per-requester write request; held high until the matching `ack`.
- `req_addr`  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- `req_data`  in  NREQ*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-cycle pulse to the served requester.
- `err`  out  1  one-cycle pulse coincident with `ack` when the served address is ≥ DEPTH.
- `ld_en`  out  DEPTH  one-hot load enable to register[a]; at most one bit high.
- `ld_data`  out  WIDTH  data for the enabled register.
- `busy`  out  1  high whenever FSM ≠ IDLE.

## Operation
- All outputs are registered. Reset values: `ack`=0, `err`=0, `ld_en`=0, `ld_data`=0, `busy`=0; FSM=IDLE; round-robin pointer `ptr`=0; latched winner, address and data = 0.
- FSM states:
  - IDLE: if any `req` bit is high, select the winner, latch its index, address and data, and go to WRITE. Otherwise stay in IDLE.
  - WRITE: drive `ld_en[addr]`=1 and `ld_data`=latched data for exactly one cycle, then go to ACK. If addr ≥ DEPTH, `ld_en` stays 0.
  - ACK: pulse `ack[winner]`=1 for one cycle, plus `err`=1 if addr ≥ DEPTH. Set `ptr` = (winner+1) mod NREQ, then go to IDLE.
- Round-robin selection: the winner is the first requester with `req` high, searching from index `ptr` upward with wrap-around at NREQ-1 → 0.
- Address and data are sampled only in IDLE. Changes to a requester's inputs after it wins are ignored.
- Requesters hold `req` until they observe `ack`, and must deassert it on the clock edge that ends the `ack` cycle. A `req` still high in IDLE is treated as a new request.
- Requests arriving while `busy` is high are not lost. They are evaluated at the next IDLE.
- Reset asserted in any state forces the reset values immediately. A write in progress is abandoned: no `ld_en` and no `ack` is emitted for it.

## Timing
- Let E0 be the rising edge at which IDLE samples `req`.
  - `ld_en`/`ld_data` are valid in the cycle E0→E1.
  - `ack` is valid in the cycle E1→E2.
  - The FSM is back in IDLE after E2.
  - The next winner is sampled at E3.
- Latency from `req` sampled to `ack` asserted: 2 cycles. Throughput: one write per 3 cycles.
- `busy` is high from E0 to E2, i.e. two cycles per transaction.
- Simultaneous requests: exactly one is served per transaction; the others stay pending.
- Every requester with `req` held high is served within NREQ transactions (3·NREQ cycles).

## Configuration
- `REG_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index requester with `req` high always wins, and `ptr` is neither updated nor used (starvation is possible by design).
- Not defined (default): round-robin selection as described in Operation.

## Test plan
- Reset with `req`=4'b1111: all outputs 0 while `rst`=0. After release, first `ld_en` targets requester 0's address and `ack`=4'b0001 two cycles after the first sample.
- Single request: requester 2 writes addr=3, data=8'hA5 → `ld_en`=4'b1000 and `ld_data`=8'hA5 for one cycle, then `ack`=4'b0100 for one cycle; `busy` high for exactly 2 cycles.
- All four requesters held high → `ack` order 0,1,2,3,0 at 3-cycle spacing. With `REG_ARB_FIXED_PRIO_EN`, order is 0,0,0… while `req[0]` stays high.
- Out of range, with DEPTH=3: requester 1 writes addr=3 → `ld_en` remains 0, then `ack`=4'b0010 with `err`=1 in the same cycle.
- Reset mid-op: drop `rst` during the WRITE cycle → `ld_en` clears immediately, no `ack` follows, and `ptr` restarts at 0.
- Data stability: change `req_data` of the winner during WRITE → `ld_data` still shows the value sampled at E0.
